// File: rtl/exec_dispatch_unit_pkg.sv
// Shared types and constants for the instruction dispatcher.
// Holds the FSM state encoding, fault codes and the default opcode match table.
package exec_dispatch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        FAULT = 2'd2
    } dispatch_state_e;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    // unit0 = ALU (100), unit1 = PFCU (110), unit2 = MIOU (010)
    localparam logic [8:0] OPC_TABLE_DEFAULT = {3'b010, 3'b110, 3'b100};

endpackage

// File: rtl/exec_dispatch_unit_opc_decoder.sv
// Combinational opcode matcher: compares the select field against every unit's
// table entry and reports the lowest matching unit index.
module dispatch_opc_decoder
    import exec_dispatch_unit_pkg::*;
#(
    parameter int                        NUM_EU    = 3,
    parameter int                        SEL_W     = 3,
    parameter logic [NUM_EU*SEL_W-1:0]   OPC_TABLE = OPC_TABLE_DEFAULT,
    parameter int                        IDX_W     = (NUM_EU > 1) ? $clog2(NUM_EU) : 1
) (
    input  logic [SEL_W-1:0]  opc,
    output logic [NUM_EU-1:0] match,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        for (int i = 0; i < NUM_EU; i++) begin
            match[i] = (opc == OPC_TABLE[i*SEL_W +: SEL_W]);
        end
    end

    // Scan high to low so the last assignment, the lowest index, wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_EU - 1; i >= 0; i--) begin
            if (match[i]) begin
                valid = 1'b1;
                idx   = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/exec_dispatch_unit.sv
// Dispatches one queued instruction at a time to the matching execution unit,
// with illegal-opcode trap, per-instruction watchdog and retired-instruction count.
//
//  state | meaning
//  IDLE  | ready for next instruction (inst_re=1)
//  EXEC  | selected unit enabled and owns the GPR write path
//  FAULT | illegal opcode or watchdog expiry; sticky until fault_clr
module exec_dispatch_unit
    import exec_dispatch_unit_pkg::*;
#(
    parameter int                        NUM_EU    = 3,
    parameter int                        INST_W    = 32,
    parameter int                        SEL_W     = 3,
    parameter logic [NUM_EU*SEL_W-1:0]   OPC_TABLE = OPC_TABLE_DEFAULT,
    parameter int                        NUM_REGS  = 16,
    parameter int                        DATA_W    = 32,
    parameter int                        TIMEOUT   = 1024,
    parameter int                        TMR_W     = 16
) (
    input  logic                                cclk,
    input  logic                                rst,
    input  logic                                inst_av,
    input  logic [INST_W-1:0]                   inst_dat,
    output logic                                inst_re,
    output logic [NUM_EU-1:0]                   eu_en,
    input  logic [NUM_EU-1:0]                   eu_done,
    output logic [INST_W-1:0]                   eu_inst,
    input  logic [NUM_EU*NUM_REGS-1:0]          eu_gpr_we,
    input  logic [NUM_EU*NUM_REGS*DATA_W-1:0]   eu_gpr_wdat,
    output logic [NUM_REGS-1:0]                 gpr_we,
    output logic [NUM_REGS*DATA_W-1:0]          gpr_wdat,
    output logic                                fault,
    output logic [1:0]                          fault_code,
    input  logic                                fault_clr,
    output logic [31:0]                         retired_cnt
);

    localparam int IDX_W = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;

    // Watchdog counts down from TIMEOUT-1; reaching zero without done is the
    // TIMEOUT-th EXEC cycle.
    localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

    dispatch_state_e    state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [INST_W-1:0]  eu_inst_q, eu_inst_d;
    logic [1:0]         fault_code_q, fault_code_d;
    logic [31:0]        retired_cnt_q, retired_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [NUM_EU-1:0]  opc_match_unused;
    logic               opc_valid;
    logic [IDX_W-1:0]   opc_idx;
    logic               done_sel;

    dispatch_opc_decoder #(
        .NUM_EU    (NUM_EU),
        .SEL_W     (SEL_W),
        .OPC_TABLE (OPC_TABLE),
        .IDX_W     (IDX_W)
    ) u_opc_decoder (
        .opc   (inst_dat[SEL_W-1:0]),
        .match (opc_match_unused),
        .valid (opc_valid),
        .idx   (opc_idx)
    );

    assign done_sel = eu_done[sel_q];

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        eu_inst_d     = eu_inst_q;
        fault_code_d  = fault_code_q;
        retired_cnt_d = retired_cnt_q;
        timer_d       = timer_q;
        case (state_q)
            IDLE: begin
                if (inst_av) begin
                    eu_inst_d = inst_dat;
                    if (opc_valid) begin
                        sel_d   = opc_idx;
                        timer_d = TMR_LOAD;
                        state_d = EXEC;
                    end else begin
                        fault_code_d = FLT_ILLEGAL;
                        state_d      = FAULT;
                    end
                end
            end
            EXEC: begin
                if (done_sel) begin
                    retired_cnt_d = retired_cnt_q + 32'd1;
                    state_d       = IDLE;
                end else if ((TIMEOUT != 0) && (timer_q == '0)) begin
                    fault_code_d = FLT_TIMEOUT;
                    state_d      = FAULT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    fault_code_d = FLT_NONE;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            eu_inst_q     <= '0;
            fault_code_q  <= FLT_NONE;
            retired_cnt_q <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            eu_inst_q     <= eu_inst_d;
            fault_code_q  <= fault_code_d;
            retired_cnt_q <= retired_cnt_d;
            timer_q       <= timer_d;
        end
    end

    // GPR write path belongs exclusively to the selected unit while executing.
    always_comb begin
        eu_en    = '0;
        gpr_we   = '0;
        gpr_wdat = '0;
        if (state_q == EXEC) begin
            eu_en    = NUM_EU'(1) << sel_q;
            gpr_we   = eu_gpr_we[sel_q*NUM_REGS +: NUM_REGS];
            gpr_wdat = eu_gpr_wdat[sel_q*NUM_REGS*DATA_W +: NUM_REGS*DATA_W];
        end
    end

    assign inst_re     = (state_q == IDLE);
    assign fault       = (state_q == FAULT);
    assign fault_code  = fault_code_q;
    assign eu_inst     = eu_inst_q;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_exec_dispatch_unit.sv
// Self-checking bench for exec_dispatch_unit: directed sequences, an opcode
// vector table and randomized traffic against a cycle-level reference model.
module tb_exec_dispatch_unit;

    localparam int NUM_EU   = 3;
    localparam int INST_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;
    localparam int TIMEOUT  = 8;

    logic                              cclk;
    logic                              rst;
    logic                              inst_av;
    logic [INST_W-1:0]                 inst_dat;
    logic                              inst_re;
    logic [NUM_EU-1:0]                 eu_en;
    logic [NUM_EU-1:0]                 eu_done;
    logic [INST_W-1:0]                 eu_inst;
    logic [NUM_EU*NUM_REGS-1:0]        eu_gpr_we;
    logic [NUM_EU*NUM_REGS*DATA_W-1:0] eu_gpr_wdat;
    logic [NUM_REGS-1:0]               gpr_we;
    logic [NUM_REGS*DATA_W-1:0]        gpr_wdat;
    logic                              fault;
    logic [1:0]                        fault_code;
    logic                              fault_clr;
    logic [31:0]                       retired_cnt;

    exec_dispatch_unit #(
        .NUM_EU   (NUM_EU),
        .INST_W   (INST_W),
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .TMR_W    (16)
    ) dut (
        .cclk        (cclk),
        .rst         (rst),
        .inst_av     (inst_av),
        .inst_dat    (inst_dat),
        .inst_re     (inst_re),
        .eu_en       (eu_en),
        .eu_done     (eu_done),
        .eu_inst     (eu_inst),
        .eu_gpr_we   (eu_gpr_we),
        .eu_gpr_wdat (eu_gpr_wdat),
        .gpr_we      (gpr_we),
        .gpr_wdat    (gpr_wdat),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_clr   (fault_clr),
        .retired_cnt (retired_cnt)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: which unit is busy, how many EXEC cycles elapsed, counts.
    logic [2:0]  opc_of [NUM_EU] = '{3'b100, 3'b110, 3'b010};
    int          m_unit;
    int          m_cycles;
    bit          m_busy;
    bit          m_fault;
    logic [1:0]  m_code;
    logic [31:0] m_ret;
    logic [31:0] m_inst;

    function automatic int ref_unit(input logic [31:0] inst);
        for (int u = 0; u < NUM_EU; u++) begin
            if (inst[2:0] == opc_of[u]) return u;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_unit = 0; m_cycles = 0; m_busy = 0; m_fault = 0;
        m_code = 2'b00; m_ret = 32'd0; m_inst = 32'd0;
    endtask

    task automatic model_cmp();
        logic [NUM_EU-1:0]          exp_en;
        logic [NUM_REGS-1:0]        exp_we;
        logic [NUM_REGS*DATA_W-1:0] exp_wd;
        exp_en = '0; exp_we = '0; exp_wd = '0;
        if (m_busy) begin
            exp_en = NUM_EU'(1 << m_unit);
            exp_we = eu_gpr_we[m_unit*NUM_REGS +: NUM_REGS];
            exp_wd = eu_gpr_wdat[m_unit*NUM_REGS*DATA_W +: NUM_REGS*DATA_W];
        end
        chk("m_inst_re", inst_re, (!m_busy && !m_fault));
        chk("m_eu_en", eu_en, exp_en);
        chk("m_fault", fault, m_fault);
        chk("m_fault_code", fault_code, m_code);
        chk("m_retired", retired_cnt, m_ret);
        chk("m_eu_inst", eu_inst, m_inst);
        chk("m_gpr_we", gpr_we, exp_we);
        chk("m_gpr_wdat", gpr_wdat, exp_wd);
    endtask

    task automatic model_step();
        int u;
        if (rst) begin
            model_reset();
        end else if (m_fault) begin
            if (fault_clr) begin
                m_fault = 0;
                m_code  = 2'b00;
            end
        end else if (m_busy) begin
            m_cycles++;
            if (eu_done[m_unit]) begin
                m_ret  = m_ret + 32'd1;
                m_busy = 0;
            end else if (m_cycles == TIMEOUT) begin
                m_busy  = 0;
                m_fault = 1;
                m_code  = 2'b10;
            end
        end else if (inst_av) begin
            m_inst = inst_dat;
            u = ref_unit(inst_dat);
            if (u >= 0) begin
                m_unit   = u;
                m_cycles = 0;
                m_busy   = 1;
            end else begin
                m_fault = 1;
                m_code  = 2'b01;
            end
        end
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic tick();
        #1;
        model_cmp();
        model_step();
        @(posedge cclk);
        #1;
    endtask

    task automatic accept(input logic [31:0] inst);
        inst_av  = 1'b1;
        inst_dat = inst;
        tick();
        inst_av  = 1'b0;
    endtask

    typedef struct {
        logic [31:0]       inst;
        logic [NUM_EU-1:0] exp_en;
        logic [1:0]        exp_code;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        tbl[0]  = '{32'h0000_0004, 3'b001, 2'b00};
        tbl[1]  = '{32'hFFFF_FFFC, 3'b001, 2'b00};
        tbl[2]  = '{32'h0000_0006, 3'b010, 2'b00};
        tbl[3]  = '{32'hABCD_0006, 3'b010, 2'b00};
        tbl[4]  = '{32'h0000_0002, 3'b100, 2'b00};
        tbl[5]  = '{32'h8000_000A, 3'b100, 2'b00};
        tbl[6]  = '{32'h0000_0000, 3'b000, 2'b01};
        tbl[7]  = '{32'h0000_0001, 3'b000, 2'b01};
        tbl[8]  = '{32'h1234_5603, 3'b000, 2'b01};
        tbl[9]  = '{32'h0000_0005, 3'b000, 2'b01};
        tbl[10] = '{32'hFFFF_FFFF, 3'b000, 2'b01};
        tbl[11] = '{32'h0000_0014, 3'b001, 2'b00};

        rst = 1'b1; inst_av = 1'b0; inst_dat = '0; eu_done = '0;
        eu_gpr_we = '0; eu_gpr_wdat = '0; fault_clr = 1'b0;
        @(posedge cclk);
        #1;
        model_reset();
        rst = 1'b0;

        chk("rst_inst_re", inst_re, 1'b1);
        chk("rst_eu_en", eu_en, 3'b000);
        chk("rst_fault", fault, 1'b0);
        chk("rst_fault_code", fault_code, 2'b00);
        chk("rst_retired", retired_cnt, 32'd0);
        chk("rst_eu_inst", eu_inst, 32'd0);

        // ALU instruction, done in the third EXEC cycle
        accept(32'h0000_0004);
        chk("alu_en", eu_en, 3'b001);
        chk("alu_inst_re", inst_re, 1'b0);
        chk("alu_eu_inst", eu_inst, 32'h0000_0004);
        tick();
        tick();
        eu_done = 3'b001;
        tick();
        eu_done = 3'b000;
        chk("alu_done_inst_re", inst_re, 1'b1);
        chk("alu_done_en", eu_en, 3'b000);
        chk("alu_retired", retired_cnt, 32'd1);

        // MIOU owns the GPR path; ALU writes are blocked
        accept(32'h0000_0012);
        chk("miou_en", eu_en, 3'b100);
        eu_gpr_we[2*NUM_REGS +: NUM_REGS] = 16'h0008;
        eu_gpr_we[0 +: NUM_REGS]          = 16'hFFFF;
        eu_gpr_wdat[(2*NUM_REGS+3)*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        eu_gpr_wdat[3*DATA_W +: DATA_W]              = 32'h1111_1111;
        #1;
        chk("miou_gpr_we", gpr_we, 16'h0008);
        chk("miou_gpr_r3", gpr_wdat[3*DATA_W +: DATA_W], 32'hDEAD_BEEF);
        eu_done = 3'b100;
        tick();
        eu_done = 3'b000;
        chk("miou_idle_gpr_we", gpr_we, 16'h0000);
        eu_gpr_we = '0; eu_gpr_wdat = '0;
        chk("miou_retired", retired_cnt, 32'd2);

        // Illegal opcode
        accept(32'h0000_0007);
        chk("ill_fault", fault, 1'b1);
        chk("ill_code", fault_code, 2'b01);
        chk("ill_en", eu_en, 3'b000);
        chk("ill_inst_re", inst_re, 1'b0);
        chk("ill_eu_inst", eu_inst, 32'h0000_0007);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("ill_clr_fault", fault, 1'b0);
        chk("ill_clr_code", fault_code, 2'b00);
        chk("ill_clr_inst_re", inst_re, 1'b1);

        // PFCU never done: watchdog after 8 EXEC cycles; other units' done ignored
        accept(32'h0000_0006);
        eu_done = 3'b101;
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("to_en_held", eu_en, 3'b010);
            tick();
        end
        eu_done = 3'b000;
        chk("to_fault", fault, 1'b1);
        chk("to_code", fault_code, 2'b10);
        chk("to_en", eu_en, 3'b000);
        chk("to_retired", retired_cnt, 32'd2);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

        // Done on the 8th cycle beats the watchdog
        accept(32'h0000_0006);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        eu_done = 3'b010;
        tick();
        eu_done = 3'b000;
        chk("to_edge_fault", fault, 1'b0);
        chk("to_edge_inst_re", inst_re, 1'b1);
        chk("to_edge_retired", retired_cnt, 32'd3);

        // Reset in the middle of EXEC
        accept(32'h0000_0004);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_en", eu_en, 3'b000);
        chk("mid_rst_retired", retired_cnt, 32'd0);
        chk("mid_rst_inst_re", inst_re, 1'b1);
        eu_done = 3'b111;
        tick();
        tick();
        tick();
        eu_done = 3'b000;
        chk("mid_rst_late_done", retired_cnt, 32'd0);

        // Opcode vector table
        for (int v = 0; v < 12; v++) begin
            accept(tbl[v].inst);
            chk("tbl_en", eu_en, tbl[v].exp_en);
            chk("tbl_code", fault_code, tbl[v].exp_code);
            chk("tbl_eu_inst", eu_inst, tbl[v].inst);
            if (tbl[v].exp_code != 2'b00) begin
                fault_clr = 1'b1;
                tick();
                fault_clr = 1'b0;
            end else begin
                eu_done = tbl[v].exp_en;
                tick();
                eu_done = 3'b000;
            end
        end

        // Back-to-back: one instruction every two cycles
        inst_av  = 1'b1;
        inst_dat = 32'h0000_0002;
        eu_done  = 3'b111;
        for (int i = 0; i < 6; i++) tick();
        inst_av = 1'b0;
        eu_done = 3'b000;
        tick();
        chk("b2b_retired", retired_cnt, m_ret);
        chk("b2b_retired_abs", retired_cnt, 32'd10);

        // Counter wrap
        force dut.retired_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt_q;
        m_ret = 32'hFFFF_FFFF;
        tick();
        chk("wrap_preload", retired_cnt, 32'hFFFF_FFFF);
        accept(32'h0000_0004);
        eu_done = 3'b001;
        tick();
        eu_done = 3'b000;
        chk("wrap_zero", retired_cnt, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            inst_av   = 1'($urandom_range(0, 1));
            inst_dat  = $urandom;
            fault_clr = ($urandom_range(0, 3) == 0);
            for (int u = 0; u < NUM_EU; u++) begin
                eu_done[u] = ($urandom_range(0, 3) == 0);
            end
            eu_gpr_we = {$urandom, $urandom};
            for (int w = 0; w < NUM_EU*NUM_REGS; w++) begin
                eu_gpr_wdat[w*DATA_W +: DATA_W] = $urandom;
            end
            tick();
        end
        rst = 1'b0; inst_av = 1'b0; eu_done = '0; fault_clr = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_dispatch_unit.md
Name: exec_dispatch_unit

Overview:
Parametrised instruction dispatcher between the instruction decoder/queue and NUM_EU execution units (ALU, PFCU, MIOU, future units) inside the core.
- Accepts one queued instruction and selects the target unit through a per-unit opcode match table.
- Holds that unit's enable until it reports done, and gives it exclusive access to the GPR write path.
- Adds behaviour the current hard-wired dispatch lacks: illegal-opcode trapping, a per-instruction watchdog timeout, and a retired-instruction counter.

Parameters:
NUM_EU, 3, number of execution units
INST_W, 32, instruction width
SEL_W, 3, opcode select field width, taken from inst[SEL_W-1:0]
OPC_TABLE, {3'b010,3'b110,3'b100}, packed NUM_EU*SEL_W bits; unit i matches OPC_TABLE[i*SEL_W +: SEL_W] (unit0=100 ALU, unit1=110 PFCU, unit2=010 MIOU)
NUM_REGS, 16, number of GPRs
DATA_W, 32, GPR width
TIMEOUT, 1024, maximum EXEC cycles before fault; 0 disables the watchdog
TMR_W, 16, watchdog counter width; must satisfy TIMEOUT < 2**TMR_W

Ports:
cclk  in  1  core clock
rst  in  1  synchronous, active-high reset
inst_av  in  1  instruction available
inst_dat  in  INST_W  instruction
inst_re  out  1  request/accept next instruction
eu_en  out  NUM_EU  one-hot unit enable
eu_done  in  NUM_EU  unit completion
eu_inst  out  INST_W  latched instruction, broadcast to all units
eu_gpr_we  in  NUM_EU*NUM_REGS  per-unit GPR write enables
eu_gpr_wdat  in  NUM_EU*NUM_REGS*DATA_W  per-unit GPR write data
gpr_we  out  NUM_REGS  GPR write enables
gpr_wdat  out  NUM_REGS*DATA_W  GPR write data
fault  out  1  sticky fault flag
fault_code  out  2  01 = illegal opcode, 10 = timeout, 00 = none
fault_clr  in  1  clear fault
retired_cnt  out  32  count of completed instructions

Behaviour:
- Reset (rst sampled high on a cclk edge, dominates all other inputs, valid in any state including mid-EXEC):
  - state = IDLE; eu_en, eu_inst, fault, fault_code, retired_cnt and the timer all clear to 0.
  - inst_re = 1 in the first cycle after reset.
- States:
  - IDLE: inst_re=1, eu_en=0.
  - EXEC: inst_re=0, eu_en=onehot(sel).
  - FAULT: inst_re=0, eu_en=0, fault=1.
- IDLE transition, on inst_av & inst_re at edge T:
  - eu_inst <= inst_dat.
  - Decode inst_dat[SEL_W-1:0] against OPC_TABLE; if several entries match, the lowest index wins.
  - On a match: sel <= index, timer <= 0, state EXEC (eu_en high from T+1).
  - With no match: state FAULT, fault_code <= 01; no unit is enabled.
- EXEC transition:
  - The timer increments every cycle.
  - eu_done[sel]=1 at edge T+n: retired_cnt increments (wrapping at 2^32), state IDLE, so eu_en drops and inst_re rises at T+n+1.
  - If timer == TIMEOUT-1 and eu_done[sel] is low (TIMEOUT≠0): state FAULT, fault_code <= 10, eu_en drops.
  - If done and timeout occur in the same cycle, done wins.
- eu_done bits from unselected units are ignored in every state.
- GPR path: combinational.
  - In EXEC: gpr_we = eu_gpr_we[sel], gpr_wdat = eu_gpr_wdat[sel].
  - In all other states: gpr_we = 0 and gpr_wdat = 0. Writes from unselected units are never forwarded.
- FAULT:
  - Sticky; eu_inst holds the faulting instruction.
  - fault_clr=1 -> IDLE next cycle with fault=0 and fault_code=00.
  - fault_clr in IDLE/EXEC has no effect.
- Minimum throughput: one instruction per 2 cycles (done returned in the first EXEC cycle).
- eu_inst is stable for the whole EXEC period.

Decomposition:
- Shared package (structs.svh / defines.svh):
  - dispatch_state_e {IDLE, EXEC, FAULT}
  - fault code constants FLT_NONE/FLT_ILLEGAL/FLT_TIMEOUT
  - default OPC_TABLE constant.
- Sub-module: dispatch_opc_decoder, a combinational lowest-index priority matcher. Outputs match, a valid flag and the index ($clog2(NUM_EU) bits).

Test Plan:
- Reset then inst_av=1 with inst_dat=0x00000004:
  - eu_en=3'b001 from the cycle after acceptance.
  - With eu_done[0] asserted 3 cycles later: inst_re=1 the next cycle and retired_cnt=1.
- MIOU instruction 0x12 in EXEC:
  - unit2 drives we=16'h0008, data 0xDEADBEEF to r3; unit0 simultaneously drives we=16'hFFFF.
  - Required: gpr_we=16'h0008 and r3 data=0xDEADBEEF.
- Instruction 0x7 (no match):
  - Required: fault=1, fault_code=01, eu_en=0, inst_re=0.
  - fault_clr pulse -> fault=0 and inst_re=1 the next cycle.
- TIMEOUT=8 with unit1 never done:
  - Required: FAULT with code 10 after 8 EXEC cycles and eu_en=0.
  - Repeat with done asserted on the 8th cycle -> retire, no fault.
- rst asserted mid-EXEC:
  - Required: next cycle eu_en=0, retired_cnt=0, inst_re=1.
  - eu_done arriving afterwards is ignored (retired_cnt stays 0).
- Preload retired_cnt near wrap (via 2^32 retirements, or by forcing the counter to 0xFFFFFFFF), then retire once:
  - Required: retired_cnt wraps to 0.
